consumer2riscv: RTL and testbench
=================================

CONSUMER2RISCV -- requirements
Module: consumer2riscv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream word width.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO capacity in words; power of two, at least 4.
REQ-003 SHALL have parameter PTR_BITS, default 3, equal to log2(DEPTH).
REQ-004 SHALL have port clk, input, 1 bit, sole clock; all state updates on rising edge.
REQ-005 SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port din, input, DATA_WIDTH bits, upstream data.
REQ-007 SHALL have port val_in, input, 1 bit, upstream word valid.
REQ-008 SHALL have port ready_upward, output, 1 bit, FIFO can accept a word.
REQ-009 SHALL have port dout, output, DATA_WIDTH bits, head word toward the picorv_mem din1..din4 input.
REQ-010 SHALL have port val_out, output, 1 bit, dout valid.
REQ-011 SHALL have port ready_downward, input, 1 bit, picorv_mem ready_upward.
REQ-012 SHALL have port count, output, PTR_BITS+1 bits, current occupancy 0..DEPTH.
REQ-013 SHALL have port almost_full, output, 1 bit, asserted when count >= DEPTH-2.
REQ-014 SHALL have port drop_cnt, output, 16 bits, count of cycles with val_in=1 while ready_upward=0.

Function
REQ-015 SHALL define push as val_in && ready_upward, and pop as val_out && ready_downward, both sampled at the rising edge.
REQ-016 SHALL drive ready_upward = (count != DEPTH), decoded from registered count only; no combinational path from ready_downward.
REQ-017 SHALL drive val_out = (count != 0), decoded from registered count only.
REQ-018 SHALL present dout first-word-fall-through: dout = mem[rd_ptr] while val_out=1, else all zeros.
REQ-019 SHALL produce latency of one cycle: a word pushed at edge N into an empty FIFO is on dout with val_out=1 from edge N until popped.
REQ-020 SHALL on push write din to mem[wr_ptr] and increment wr_ptr modulo DEPTH (wrap DEPTH-1 to 0).
REQ-021 SHALL on pop increment rd_ptr modulo DEPTH.
REQ-022 SHALL update count +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-023 SHALL, when full, not accept a word in a cycle that also pops; ready_upward stays 0 for that cycle, with no pass-through.
REQ-024 SHALL, when empty, ignore ready_downward and not return stale data to the consumer.
REQ-025 SHALL deliver words in exact push order with no duplication or loss across pointer wrap.
REQ-026 SHALL hold dout and val_out stable while val_out=1 and ready_downward=0.
REQ-027 SHALL increment drop_cnt each cycle with val_in=1 and ready_upward=0, saturating at 16'hFFFF.
REQ-028 SHALL drive almost_full from registered count only.

Reset
REQ-029 SHALL, on resetn low, immediately and asynchronously clear wr_ptr, rd_ptr, count and drop_cnt to 0.
REQ-030 SHALL read outputs during and after reset as ready_upward=1, val_out=0, dout=0, count=0, almost_full=0, drop_cnt=0.
REQ-031 SHALL keep mem contents unreset; they SHALL never be observable because of REQ-018.
REQ-032 SHALL, on reset mid-operation, discard all buffered words; the first push after release SHALL be the first word popped.
REQ-033 SHALL take no push or pop on the first rising edge after resetn deasserts if resetn was low at that edge.

Verification
REQ-034 Single word: after reset, push 32'hDEADBEEF at edge 1 with ready_downward=1 -> val_out=1 and dout=DEADBEEF after edge 1; popped at edge 2; count 1 then 0.
REQ-035 Fill/full: ready_downward=0, push 1..9 on consecutive cycles -> words 1..8 accepted, ready_upward=0 after edge 8, drop_cnt=1, almost_full=1 from count 6.
REQ-036 Full with pop: from full, val_in=1 and ready_downward=1 for one cycle -> pop only, count 7; push accepted on the next cycle.
REQ-037 Wrap: 20 words streamed with random ready_downward (50%) -> output order 1..20 exactly; count returns to 0.
REQ-038 Steady state: continuous push/pop at count=3 for 10 cycles -> count stays 3 and throughput is 1 word per cycle.
REQ-039 Mid-reset: 5 words buffered, resetn pulsed low mid-cycle -> outputs per REQ-030 without waiting for a clock edge; next push 32'h11 is popped first.

Source files
------------

// File: rtl/consumer2riscv_if.sv
// Stream handshake bundle between an upstream producer, the consumer2riscv FIFO and picorv_mem.
// Valid/ready rule: a word moves on a rising edge exactly when its valid and the receiver's ready are both 1.
interface consumer2riscv_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] din;
    logic                  val_in;
    logic                  ready_upward;
    logic [DATA_WIDTH-1:0] dout;
    logic                  val_out;
    logic                  ready_downward;

    // master: the environment driving the FIFO; slave: the FIFO itself
    modport master (
        output din, val_in, ready_downward,
        input  ready_upward, dout, val_out
    );
    modport slave (
        input  din, val_in, ready_downward,
        output ready_upward, dout, val_out
    );
endinterface

// File: rtl/consumer2riscv.sv
// First-word-fall-through FIFO feeding picorv_mem; all handshake outputs decode from registered
// occupancy, so there is no combinational path from ready_downward to ready_upward.
module consumer2riscv #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PTR_BITS   = 3
) (
    input  logic                clk,
    input  logic                resetn,
    consumer2riscv_if.slave     bus,
    output logic [PTR_BITS:0]   count,
    output logic                almost_full,
    output logic [15:0]         drop_cnt
);
    localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS:0] AF_CNT   = (PTR_BITS+1)'(DEPTH - 2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]     count_q,  count_d;
    logic [15:0]           drop_q,   drop_d;
    logic                  push, pop;

    assign bus.ready_upward = (count_q != FULL_CNT);
    assign bus.val_out      = (count_q != '0);
    assign bus.dout         = bus.val_out ? mem[rd_ptr_q] : '0;
    assign count            = count_q;
    assign almost_full      = (count_q >= AF_CNT);
    assign drop_cnt         = drop_q;

    assign push = bus.val_in && bus.ready_upward;
    assign pop  = bus.val_out && bus.ready_downward;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        drop_d = drop_q;
        if (bus.val_in && !bus.ready_upward && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is deliberately unreset; dout masks it whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= bus.din;
    end
endmodule

// File: tb/tb_consumer2riscv.sv
// Directed bench for consumer2riscv: a vector table for fill/full/drain, then scoreboard-driven
// sequences for pointer wrap, steady-state streaming and mid-cycle reset.
module tb_consumer2riscv;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    typedef struct {
        logic          val_in;
        logic [DW-1:0] din;
        logic          rdy_dn;
        logic          exp_ready;
        logic          exp_val;
        logic [DW-1:0] exp_dout;
        logic [3:0]    exp_count;
        logic          exp_af;
        logic [15:0]   exp_drop;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic [3:0]  count;
    logic        almost_full;
    logic [15:0] drop_cnt;

    consumer2riscv_if #(.DATA_WIDTH(DW)) bus ();

    consumer2riscv #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_BITS(3)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus.slave),
        .count       (count),
        .almost_full (almost_full),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q [$];
    logic [15:0]   exp_drop = 16'd0;
    vec_t          vecs [32];
    int            nvec = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic v, input logic [DW-1:0] d, input logic r,
                           input logic er, input logic ev, input logic [DW-1:0] ed,
                           input logic [3:0] ec, input logic ea, input logic [15:0] edr);
        vecs[nvec].val_in    = v;
        vecs[nvec].din       = d;
        vecs[nvec].rdy_dn    = r;
        vecs[nvec].exp_ready = er;
        vecs[nvec].exp_val   = ev;
        vecs[nvec].exp_dout  = ed;
        vecs[nvec].exp_count = ec;
        vecs[nvec].exp_af    = ea;
        vecs[nvec].exp_drop  = edr;
        nvec++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, DW'(bus.ready_upward), 1);
        chk({tag, "_val"},   DW'(bus.val_out), 0);
        chk({tag, "_dout"},  bus.dout, 0);
        chk({tag, "_count"}, DW'(count), 0);
        chk({tag, "_af"},    DW'(almost_full), 0);
        chk({tag, "_drop"},  DW'(drop_cnt), 0);
    endtask

    // One clock of scoreboarded traffic; called 1 time unit after a rising edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, output logic acc);
        logic full, pop;
        full = (exp_q.size() == DEPTH);
        bus.val_in = v;
        bus.din = d;
        bus.ready_downward = r;
        chk("ready_up", DW'(bus.ready_upward), DW'(!full));
        if (exp_q.size() != 0) chk("head", bus.dout, exp_q[0]);
        else                   chk("empty_dout", bus.dout, 0);
        acc = v && !full;
        pop = r && (exp_q.size() != 0);
        if (v && full && exp_drop != 16'hFFFF) exp_drop++;
        @(posedge clk);
        #1;
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(d);
        chk("count", DW'(count), DW'(exp_q.size()));
        chk("drop", DW'(drop_cnt), DW'(exp_drop));
        chk("val_out", DW'(bus.val_out), DW'(exp_q.size() != 0));
    endtask

    initial begin
        logic [DW-1:0] seq [8];
        logic          acc;
        int            next;
        int            cyc;

        // single word
        add_vec(1, 32'hDEADBEEF, 1, 1, 1, 32'hDEADBEEF, 1, 0, 0);
        add_vec(0, 0,            1, 1, 0, 0,            0, 0, 0);
        // fill with 1..9 while picorv_mem stalls; word 9 is dropped
        for (int k = 1; k <= 9; k++) begin
            int c;
            c = (k > 8) ? 8 : k;
            add_vec(1, DW'(k), 0, c != 8, 1, 1, 4'(c), c >= 6, (k == 9) ? 16'd1 : 16'd0);
        end
        // full with pop: pop only, offered word counted as a drop, then accepted next cycle
        add_vec(1, 32'd10, 1, 1, 1, 2, 7, 1, 2);
        add_vec(1, 32'd10, 0, 0, 1, 2, 8, 1, 2);
        seq[0] = 2; seq[1] = 3; seq[2] = 4; seq[3] = 5;
        seq[4] = 6; seq[5] = 7; seq[6] = 8; seq[7] = 10;
        for (int j = 1; j <= 8; j++)
            add_vec(0, 0, 1, 1, j != 8, (j < 8) ? seq[j] : 32'd0, 4'(8 - j), (8 - j) >= 6, 2);

        bus.val_in = 0;
        bus.din = 0;
        bus.ready_downward = 0;
        resetn = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("in_reset");
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;
        chk_reset_outputs("after_reset");

        for (int i = 0; i < nvec; i++) begin
            bus.val_in = vecs[i].val_in;
            bus.din = vecs[i].din;
            bus.ready_downward = vecs[i].rdy_dn;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ready", i), DW'(bus.ready_upward), DW'(vecs[i].exp_ready));
            chk($sformatf("v%0d_val", i),   DW'(bus.val_out),      DW'(vecs[i].exp_val));
            chk($sformatf("v%0d_dout", i),  bus.dout,              vecs[i].exp_dout);
            chk($sformatf("v%0d_count", i), DW'(count),            DW'(vecs[i].exp_count));
            chk($sformatf("v%0d_af", i),    DW'(almost_full),      DW'(vecs[i].exp_af));
            chk($sformatf("v%0d_drop", i),  DW'(drop_cnt),         DW'(vecs[i].exp_drop));
        end
        exp_drop = 16'd2;

        // wrap: 20 words with random downstream stalls
        next = 1;
        cyc = 0;
        while ((next <= 20 || exp_q.size() != 0) && cyc < 300) begin
            cycle(next <= 20, DW'(next), 1'($urandom_range(0, 1)), acc);
            if (acc) next++;
            cyc++;
        end
        chk("wrap_all_pushed", DW'(next), 21);
        chk("wrap_count_zero", DW'(count), 0);

        // steady state at occupancy 3
        for (int i = 0; i < 3; i++) cycle(1, 32'h100 + DW'(i), 0, acc);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 32'h103 + DW'(i), 1, acc);
            chk("steady_acc", DW'(acc), 1);
            chk("steady_count", DW'(count), 3);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, acc);

        // mid-cycle reset with 5 words buffered
        for (int i = 0; i < 5; i++) cycle(1, 32'hA0 + DW'(i), 0, acc);
        bus.val_in = 0;
        #2;
        resetn = 0;
        #1;
        chk_reset_outputs("mid_reset");
        exp_q.delete();
        exp_drop = 0;
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;
        cycle(1, 32'h11, 0, acc);
        chk("post_reset_head", bus.dout, 32'h11);
        cycle(0, 0, 1, acc);
        chk("post_reset_empty", DW'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
